image_select_controller: RTL and testbench
==========================================

IMAGE_SELECT_CONTROLLER -- requirements
Module: image_select_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable cycles required to accept a button level (10 ms at 25 MHz).
REQ-002 Parameter NUM_IMAGES, default 3, is the number of selectable images; legal range is 2..16.
REQ-003 Port i_CLK, input, 1 bit, is the VGA pixel clock; it is the block's only clock.
REQ-004 Port i_RESET_N, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port i_CYCLE_IMAGE, input, 1 bit, is the raw tactile button (asynchronous, active-low: 0 = pressed).
REQ-006 Port i_BLANK_DISPLAY, input, 1 bit, is the raw tactile button (asynchronous, active-low: 0 = pressed).
REQ-007 Port i_FRAME_START, input, 1 bit, is a one-cycle pulse from the scanline driver at the first cycle of vertical blanking.
REQ-008 Port o_IMAGE_SEL, output, $clog2(NUM_IMAGES) bits, is the index of the image the image driver renders.
REQ-009 Port o_BLANK, output, 1 bit, forces the image driver to output black when 1.
REQ-010 Port o_PENDING, output, 1 bit, is 1 while an accepted press has not yet been applied to o_IMAGE_SEL/o_BLANK.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL have an independent debouncer: a stable-level register plus a counter wide enough for DEBOUNCE_CYCLES-1.
REQ-013 Debouncer counter: cleared whenever the synchronized level equals the stable level; incremented otherwise.
REQ-014 Debouncer accept: when the counter is DEBOUNCE_CYCLES-1 and the level still differs, the stable level SHALL update and the counter SHALL clear in the same cycle.
REQ-015 Bounce: a glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable level.
REQ-016 Press event: a one-cycle pulse on the stable level's 1->0 transition; releases generate no event.
REQ-017 A cycle-press event SHALL set the pending-cycle flag; a blank-press event SHALL set the pending-blank flag.
REQ-018 Each flag saturates: further presses before it is applied are dropped, giving at most one step per frame.
REQ-019 Apply point: on the cycle i_FRAME_START=1, each set flag SHALL be applied and cleared, with outputs updating on the next edge.
REQ-020 Cycle application: o_IMAGE_SEL <= o_IMAGE_SEL+1, wrapping from NUM_IMAGES-1 to 0.
REQ-021 Blank application: o_BLANK <= ~o_BLANK.
REQ-022 Simultaneous event and i_FRAME_START in the same cycle: the event SHALL be applied at that frame start, and no flag remains set.
REQ-023 o_PENDING SHALL equal the OR of the two flags, registered.
REQ-024 o_IMAGE_SEL and o_BLANK SHALL change only on an apply cycle, so no mid-frame change is possible.

Reset
REQ-025 Assertion of i_RESET_N=0 SHALL act immediately and asynchronously.
REQ-026 Reset values: synchronizer flops and stable levels = 1 (released); counters = 0; flags = 0; o_IMAGE_SEL = 0; o_BLANK = 0; o_PENDING = 0.
REQ-027 Reset mid-debounce or with a flag pending SHALL discard the in-flight press.
REQ-028 Deassertion is sampled on i_CLK; the first event is possible no earlier than 2+DEBOUNCE_CYCLES cycles after release.

Configuration
REQ-029 Macro IMAGE_SELECT_FRAME_SYNC_EN, defined: apply behaviour per REQ-019..REQ-024.
REQ-030 Macro IMAGE_SELECT_FRAME_SYNC_EN, undefined: i_FRAME_START is ignored, every event is applied on the cycle it occurs (outputs change the next edge), and o_PENDING is tied 0.

Verification (DEBOUNCE_CYCLES=4, NUM_IMAGES=3, macro defined unless noted)
REQ-031 Scenario: reset, then hold i_CYCLE_IMAGE=0 for 20 cycles, then pulse i_FRAME_START.
- Required: o_PENDING=1 exactly 2+4+2 cycles after the press.
- Required: o_IMAGE_SEL 0->1 one cycle after the pulse, and o_PENDING returns to 0.
REQ-032 Scenario: i_CYCLE_IMAGE glitches low for 3 cycles, repeated 5 times.
- Required: o_PENDING stays 0 and o_IMAGE_SEL stays 0.
REQ-033 Scenario: three clean cycle presses, each followed by i_FRAME_START.
- Required: o_IMAGE_SEL sequence 1, 2, 0 (wrap-around).
REQ-034 Scenario: two cycle presses plus one blank press, all before a single i_FRAME_START.
- Required: o_IMAGE_SEL 0->1 only and o_BLANK 0->1.
- Required: a second i_FRAME_START produces no further change.
REQ-035 Scenario: press accepted with o_PENDING=1, then i_RESET_N=0 asynchronously for 1 cycle, then i_FRAME_START.
- Required: o_PENDING=0, o_IMAGE_SEL=0 and o_BLANK=0 immediately, and they remain so.
REQ-036 Scenario: macro undefined, one clean blank press, no i_FRAME_START.
- Required: o_BLANK=1 one cycle after the event, and o_PENDING stays 0.

Source files
------------

// File: rtl/image_select_controller.sv
// -----------------------------------------------------------------------------
// image_select_controller
//
// Turns two raw, bouncy, active-low tactile buttons into clean image-selection
// state for a VGA image driver:
//   * "cycle image" steps o_IMAGE_SEL through 0..NUM_IMAGES-1 (wrapping),
//   * "blank display" toggles o_BLANK (image driver outputs black when 1).
//
// Each button runs through a 2-flop synchronizer and an independent debouncer
// (stable-level register + run counter). A press event is a one-cycle pulse
// on the stable level's 1->0 transition; releases produce nothing.
//
// Configuration macro: IMAGE_SELECT_FRAME_SYNC_EN
//   defined   : press events set a saturating pending flag per button; flags
//               are applied only on the cycle i_FRAME_START=1, so the image
//               never changes mid-frame. o_PENDING = registered OR of flags.
//   undefined : i_FRAME_START is ignored, every event is applied on the cycle
//               it occurs, and o_PENDING is tied to 0.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a new level
//   NUM_IMAGES      : number of selectable images, legal range 2..16
//
// Ports
//   i_CLK           : VGA pixel clock, the only clock
//   i_RESET_N       : asynchronous active-low reset
//   i_CYCLE_IMAGE   : raw button, active-low (0 = pressed), asynchronous
//   i_BLANK_DISPLAY : raw button, active-low (0 = pressed), asynchronous
//   i_FRAME_START   : one-cycle pulse at first cycle of vertical blanking
//   o_IMAGE_SEL     : index of the image to render
//   o_BLANK         : force black output when 1
//   o_PENDING       : an accepted press is waiting for the next frame start
// -----------------------------------------------------------------------------
module image_select_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_IMAGES      = 3
) (
  input  logic                          i_CLK,
  input  logic                          i_RESET_N,
  input  logic                          i_CYCLE_IMAGE,
  input  logic                          i_BLANK_DISPLAY,
  input  logic                          i_FRAME_START,
  output logic [$clog2(NUM_IMAGES)-1:0] o_IMAGE_SEL,
  output logic                          o_BLANK,
  output logic                          o_PENDING
);

  localparam int SEL_W = $clog2(NUM_IMAGES);
  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_IMAGES - 1);

  // Button lane indices into the per-button vectors below.
  localparam int BTN_CYCLE = 0;
  localparam int BTN_BLANK = 1;
  localparam int NUM_BTN   = 2;

  // ---------------------------------------------------------------------------
  // Synchronizer + debouncer state, one lane per button
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;

  logic [NUM_BTN-1:0] sync1_q,  sync1_d;
  logic [NUM_BTN-1:0] sync2_q,  sync2_d;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] press_q,  press_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // Apply strobes feeding the output registers (one per button).
  logic apply_cycle;
  logic apply_blank;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             blank_q, blank_d;

  assign btn_raw = {i_BLANK_DISPLAY, i_CYCLE_IMAGE};

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      cnt_d[b] = '0;
      // Counter runs only while the synchronized level disagrees with the
      // accepted level; any agreeing sample restarts the run from zero.
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_MAX) begin
          stable_d[b] = sync2_q[b];
          // Only the released->pressed (1->0) acceptance is an event.
          press_d[b]  = ~sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      // Buttons idle high, so synchronizers and stable levels reset released.
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int b = 0; b < NUM_BTN; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Apply policy
  // ---------------------------------------------------------------------------
`ifdef IMAGE_SELECT_FRAME_SYNC_EN
  logic cycle_flag_q, cycle_flag_d;
  logic blank_flag_q, blank_flag_d;
  logic pending_q,    pending_d;
  logic cycle_want;
  logic blank_want;

  always_comb begin
    // A press arriving on the frame-start cycle folds straight into this
    // apply; a flag that is already set absorbs extra presses (saturation).
    cycle_want   = cycle_flag_q | press_q[BTN_CYCLE];
    blank_want   = blank_flag_q | press_q[BTN_BLANK];
    apply_cycle  = i_FRAME_START & cycle_want;
    apply_blank  = i_FRAME_START & blank_want;
    cycle_flag_d = i_FRAME_START ? 1'b0 : cycle_want;
    blank_flag_d = i_FRAME_START ? 1'b0 : blank_want;
    pending_d    = cycle_flag_q | blank_flag_q;
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      cycle_flag_q <= 1'b0;
      blank_flag_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      cycle_flag_q <= cycle_flag_d;
      blank_flag_q <= blank_flag_d;
      pending_q    <= pending_d;
    end
  end

  assign o_PENDING = pending_q;
`else
  // Frame start has no role when events apply immediately.
  logic unused_frame_start;
  assign unused_frame_start = i_FRAME_START;

  always_comb begin
    apply_cycle = press_q[BTN_CYCLE];
    apply_blank = press_q[BTN_BLANK];
  end

  assign o_PENDING = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output registers: change only on an apply strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d   = sel_q;
    blank_d = blank_q;
    if (apply_cycle) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end
    if (apply_blank) begin
      blank_d = ~blank_q;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      sel_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      blank_q <= blank_d;
    end
  end

  assign o_IMAGE_SEL = sel_q;
  assign o_BLANK     = blank_q;

endmodule

// File: tb/tb_image_select_controller.sv
// -----------------------------------------------------------------------------
// tb_image_select_controller
//
// Directed scenarios (reset, clean press timing, bounce rejection, wrap-around,
// saturation, asynchronous reset, immediate-apply mode) followed by randomized
// button/frame-start traffic. A behavioural reference model tracks button
// history as a sample window and the selection as plain modular arithmetic;
// every cycle the DUT outputs are compared against it. Follows the
// IMAGE_SELECT_FRAME_SYNC_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_image_select_controller;

  localparam int D    = 4;
  localparam int N    = 3;
  localparam int SW   = $clog2(N);
  localparam int HIST = D + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_cycle;
  logic          btn_blank;
  logic          frame_start;
  logic [SW-1:0] image_sel;
  logic          blank;
  logic          pending;

  int n_checks = 0;
  int n_fail   = 0;

  image_select_controller #(
    .DEBOUNCE_CYCLES(D),
    .NUM_IMAGES     (N)
  ) dut (
    .i_CLK          (clk),
    .i_RESET_N      (rst_n),
    .i_CYCLE_IMAGE  (btn_cycle),
    .i_BLANK_DISPLAY(btn_blank),
    .i_FRAME_START  (frame_start),
    .o_IMAGE_SEL    (image_sel),
    .o_BLANK        (blank),
    .o_PENDING      (pending)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // m_hist[b][i] : raw level sampled i+1 edges ago (index 0 = most recent)
  // ---------------------------------------------------------------------------
  bit m_hist  [2][HIST];
  bit m_stable[2];
  bit m_press [2];
  bit m_flag  [2];
  bit m_pend;
  int m_sel;
  bit m_blank;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < HIST; i++) m_hist[b][i] = 1'b1;
      m_stable[b] = 1'b1;
      m_press[b]  = 1'b0;
      m_flag[b]   = 1'b0;
    end
    m_pend  = 1'b0;
    m_sel   = 0;
    m_blank = 1'b0;
  endtask

  task automatic model_apply(input int b);
    if (b == 0) m_sel = (m_sel + 1) % N;
    else        m_blank = !m_blank;
  endtask

  task automatic model_step(input bit raw0, input bit raw1, input bit fs);
    bit raw [2];
    bit new_press [2];
    bit pend_new;
    raw[0] = raw0;
    raw[1] = raw1;
    // Debounce: the level seen by the logic lags the pin by two edges; a new
    // level is accepted once the last D of those samples all disagree.
    for (int b = 0; b < 2; b++) begin
      bit all_diff = 1'b1;
      for (int i = 1; i <= D; i++)
        if (m_hist[b][i] == m_stable[b]) all_diff = 1'b0;
      new_press[b] = all_diff && m_stable[b];
      if (all_diff) m_stable[b] = !m_stable[b];
    end
    pend_new = 1'b0;
`ifdef IMAGE_SELECT_FRAME_SYNC_EN
    pend_new = m_flag[0] || m_flag[1];
    for (int b = 0; b < 2; b++) begin
      bit want = m_flag[b] || m_press[b];
      if (fs) begin
        if (want) model_apply(b);
        m_flag[b] = 1'b0;
      end else begin
        m_flag[b] = want;
      end
    end
`else
    for (int b = 0; b < 2; b++)
      if (m_press[b]) model_apply(b);
`endif
    for (int b = 0; b < 2; b++) begin
      m_press[b] = new_press[b];
      for (int i = HIST - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = raw[b];
    end
    m_pend = pend_new;
  endtask

  // ---------------------------------------------------------------------------
  // Checking and clocking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(btn_cycle, btn_blank, frame_start);
    @(negedge clk);
    check("model_sel",     image_sel, m_sel);
    check("model_blank",   blank,     m_blank);
    check("model_pending", pending,   m_pend);
  endtask

  // Asynchronous reset pulse, asserted mid-cycle and checked before any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_sel",     image_sel, 0);
    check("async_rst_blank",   blank,     0);
    check("async_rst_pending", pending,   0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic press(input int b);
    if (b == 0) btn_cycle = 1'b0; else btn_blank = 1'b0;
    repeat (D + 6) tick();
    if (b == 0) btn_cycle = 1'b1; else btn_blank = 1'b1;
    repeat (D + 6) tick();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    btn_cycle   = 1'b1;
    btn_blank   = 1'b1;
    frame_start = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_sel",     image_sel, 0);
    check("reset_blank",   blank,     0);
    check("reset_pending", pending,   0);
    rst_n = 1'b1;
    tick();

    // Clean press held 20 cycles, then a frame start.
    do_reset();
    btn_cycle = 1'b0;
    repeat (6) tick();
    check("a_sel_before_accept", image_sel, 0);
    tick();
`ifdef IMAGE_SELECT_FRAME_SYNC_EN
    check("a_pending_at_7", pending, 0);
    tick();
    check("a_pending_at_8", pending, 1);
    check("a_sel_held",     image_sel, 0);
    repeat (12) tick();
    btn_cycle = 1'b1;
    repeat (8) tick();
    frame_pulse();
    check("a_sel_after_frame", image_sel, 1);
    tick();
    check("a_pending_cleared", pending, 0);
`else
    check("a_sel_immediate", image_sel, 1);
    repeat (13) tick();
    btn_cycle = 1'b1;
    repeat (8) tick();
    frame_pulse();
    check("a_sel_ignores_frame", image_sel, 1);
`endif

    // Bounce: five 3-cycle glitches never reach D stable cycles.
    do_reset();
    repeat (5) begin
      btn_cycle = 1'b0;
      repeat (3) tick();
      btn_cycle = 1'b1;
      repeat (3) tick();
    end
    repeat (10) tick();
    check("b_pending", pending, 0);
    frame_pulse();
    check("b_sel", image_sel, 0);

    // Three clean presses each followed by a frame start: 1, 2, 0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(0);
      frame_pulse();
      check("c_wrap_sel", image_sel, (i + 1) % N);
    end

    // Two cycle presses + one blank press before a single frame start.
    do_reset();
    press(0);
    press(0);
    press(1);
    frame_pulse();
`ifdef IMAGE_SELECT_FRAME_SYNC_EN
    check("d_sel_saturated", image_sel, 1);
`else
    check("d_sel_immediate", image_sel, 2);
`endif
    check("d_blank", blank, 1);
    repeat (3) tick();
    frame_pulse();
    tick();
`ifdef IMAGE_SELECT_FRAME_SYNC_EN
    check("d_sel_second_frame", image_sel, 1);
`else
    check("d_sel_second_frame", image_sel, 2);
`endif
    check("d_blank_second_frame", blank, 1);

    // Reset while a press is pending discards it.
    do_reset();
    press(0);
`ifdef IMAGE_SELECT_FRAME_SYNC_EN
    check("e_pending_before_reset", pending, 1);
`else
    check("e_sel_before_reset", image_sel, 1);
`endif
    do_reset();
    frame_pulse();
    repeat (4) tick();
    check("e_sel",     image_sel, 0);
    check("e_blank",   blank,     0);
    check("e_pending", pending,   0);

`ifndef IMAGE_SELECT_FRAME_SYNC_EN
    // Immediate mode: blank toggles one cycle after the event.
    do_reset();
    btn_blank = 1'b0;
    repeat (6) tick();
    check("f_blank_before", blank, 0);
    tick();
    check("f_blank_after", blank, 1);
    check("f_pending",     pending, 0);
    btn_blank = 1'b1;
    repeat (8) tick();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) btn_cycle = ~btn_cycle;
      if ($urandom_range(5) == 0) btn_blank = ~btn_blank;
      frame_start = ($urandom_range(15) == 0);
      if ($urandom_range(599) == 0) begin
        frame_start = 1'b0;
        do_reset();
      end else begin
        tick();
      end
    end
    frame_start = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
